ntt_ctrl: RTL
=============

# ntt_ctrl

Sequencing controller for the ML-DSA number-theoretic transform. It drives one `BT_unit` butterfly and a 256-entry coefficient RAM through all 8 layers of an in-place forward NTT. Each cycle it issues one butterfly: read addresses, zeta index and `en`. It then returns results through a write-back delay line matched to the butterfly latency. It sits between the top-level ML-DSA sequencer (`start`/`done`) and the `BT_unit`/coefficient RAM/zeta ROM datapath.

## Interface
Parameters:
- `BT_LAT`, 4, cycles from `BT_unit.en` to `BT_unit.valid`

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request, sampled only in IDLE
- `inv`  in  1  transform direction, sampled with `start` (only with `NTT_CTRL_INTT_EN`)
- `busy`  out  1  high from the cycle after accepted `start` through the `done` cycle
- `done`  out  1  one-cycle pulse, transform complete
- `err`  out  1  sticky; `bt_valid` disagreed with the expected write-back; cleared by accepted `start`
- `rd_en`  out  1  coefficient RAM read strobe; synchronous RAM, data valid next cycle
- `rd_addr_a`, `rd_addr_b`  out  8  butterfly operand addresses j, j+len
- `zeta_idx`  out  8  zeta ROM address; registered ROM aligned with RAM read data
- `zeta_neg`  out  1  negate zeta (only with `NTT_CTRL_INTT_EN`)
- `bt_en`  out  1  to `BT_unit.en`; equals `rd_en` delayed 1 cycle
- `bt_valid`  in  1  from `BT_unit.valid`
- `wr_en`  out  1  coefficient RAM write strobe for `A_out`/`B_out`
- `wr_addr_a`, `wr_addr_b`  out  8  write-back addresses

## Operation
- States: IDLE → RUN on `start`. RUN → DRAIN after butterfly 127 of a layer is issued. DRAIN → RUN (next layer) when the delay line is empty. DRAIN → DONE after layer 7 drains. DONE → IDLE unconditionally.
- Counters: `layer` is 3 bits and `bf` is 7 bits. `bf` wraps 127→0 on a layer change.
- Forward (Cooley-Tukey) addressing:
  - len = 128>>layer, grp = bf>>(7−layer), off = bf & (len−1).
  - a = grp·2·len + off, b = a + len.
  - zeta_idx = (1<<layer) + grp, zeta_neg = 0.
- Inverse (Gentleman-Sande) addressing, `inv`=1:
  - len = 1<<layer, grp = bf>>layer, a/b as above.
  - zeta_idx = (256>>layer) − 1 − grp, zeta_neg = 1.
  - Final n⁻¹ scaling is out of scope.
- Write-back delay line: `BT_LAT`+1 stages holding {valid, a, b}, loaded by `rd_en`. `wr_en` and `wr_addr_*` come from the tail stage.
- `err` sets whenever the tail valid ≠ `bt_valid`. The write still follows the tail.
- Layers never overlap: the next layer starts only after every write of the current layer has completed.
- `start` in any state other than IDLE is ignored.
- Reset mid-operation: next cycle is IDLE with all outputs 0 and the delay line cleared. No further `wr_en`.

## Timing
- Reset value of every output is 0.
- Accepted `start` at cycle c: first `rd_en` at c+1.
- Within a layer: reads issue on 128 consecutive cycles.
- Each butterfly read at cycle t gives `bt_en` at t+1 and `wr_en` at t+1+`BT_LAT`.
- Layer period P = 129 + `BT_LAT` cycles (first read to first read of the next layer).
- `done` rises at c+1+8P. With `BT_LAT`=4 this is c+1065.
- `busy` is high from c+1 to c+1+8P inclusive.
- `start` on the cycle after `done` is accepted.

## Configuration
- `NTT_CTRL_INTT_EN` defined:
  - `inv` and `zeta_neg` ports exist.
  - Inverse addressing and descending zeta index are compiled in.
- `NTT_CTRL_INTT_EN` undefined:
  - Forward only; `inv` and `zeta_neg` ports are absent.
  - Zeta index logic is forward-only.

## Structure
- Shared package `ntt_pkg`:
  - N=256, LOG_N=8, Q=8380417, COEF_W=23.
  - FSM state enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module `ntt_addr_gen`: combinational (layer, bf, inv) → (a, b, zeta_idx, zeta_neg).
- Delay line and FSM live in `ntt_ctrl`.

## Test plan
- Reset held 3 cycles → every output 0. `start` while `reset`=1 → no `rd_en`.
- Forward start, `BT_LAT`=4 → first issue a=0, b=128, zeta 1.
  - Layer 1, bf 64 → a=128, b=192, zeta 3.
  - Layer 7, bf 5 → a=10, b=11, zeta 133.
- Forward full run with the `BT_unit` model echoing `valid` → `done` at c+1065, exactly 1024 `wr_en` pulses.
  - Addresses match the reads delayed by 5 cycles.
  - `err`=0.
- `inv`=1 (macro on) → layer 0, bf 0: a=0, b=1, zeta 255, neg=1.
  - Layer 7, bf 0: a=0, b=128, zeta 1.
- `reset` at layer 3, bf 40 → next cycle IDLE, outputs 0, no further `wr_en`.
  - New `start` restarts at layer 0, bf 0. `start` pulsed while busy → ignored, `done` timing unchanged.
- Bench drops one `bt_valid` pulse → `err`=1 from that cycle until the next accepted `start`.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and types for the ML-DSA NTT datapath and its controller.
// Used with or without NTT_CTRL_INTT_EN; nothing here depends on that macro.
package ntt_pkg;

    localparam int unsigned N      = 256;
    localparam int unsigned LOG_N  = 8;
    localparam int unsigned Q      = 8380417;
    localparam int unsigned COEF_W = 23;
    localparam int unsigned ADDR_W = LOG_N;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } ntt_state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
    } wb_entry_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address / zeta index generator for one (layer, bf) pair.
// Inverse (Gentleman-Sande) addressing is compiled in only with NTT_CTRL_INTT_EN.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [2:0]        layer,
`ifdef NTT_CTRL_INTT_EN
    input  logic              inv,
`endif
    input  logic [6:0]        bf,
    output logic [ADDR_W-1:0] a,
    output logic [ADDR_W-1:0] b,
`ifdef NTT_CTRL_INTT_EN
    output logic              zeta_neg,
`endif
    output logic [ADDR_W-1:0] zeta_idx
);

    logic [8:0] len;
    logic [8:0] grp;
    logic [8:0] off;
    logic [8:0] base;
    logic [8:0] zeta;

    always_comb begin
        // grp * 2 * len is formed as a shift since 2*len is a power of two
        len  = 9'd128 >> layer;
        grp  = {2'b00, bf} >> (3'd7 - layer);
        base = grp << (4'd8 - {1'b0, layer});
        zeta = (9'd1 << layer) + grp;
`ifdef NTT_CTRL_INTT_EN
        zeta_neg = 1'b0;
        if (inv) begin
            len      = 9'd1 << layer;
            grp      = {2'b00, bf} >> layer;
            base     = grp << ({1'b0, layer} + 4'd1);
            zeta     = (9'd256 >> layer) - 9'd1 - grp;
            zeta_neg = 1'b1;
        end
`endif
        off      = {2'b00, bf} & (len - 9'd1);
        a        = 8'(base + off);
        b        = 8'(base + off + len);
        zeta_idx = 8'(zeta);
    end

endmodule

// File: rtl/ntt_ctrl.sv
// ML-DSA NTT sequencing controller: issues one butterfly per cycle over 8 layers
// and returns write-backs through a BT_LAT+1 delay line. Inverse via NTT_CTRL_INTT_EN.
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int unsigned BT_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef NTT_CTRL_INTT_EN
    input  logic              inv,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [ADDR_W-1:0] zeta_idx,
`ifdef NTT_CTRL_INTT_EN
    output logic              zeta_neg,
`endif
    output logic              bt_en,
    input  logic              bt_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b
);

    ntt_state_t        state, state_nxt;
    logic [2:0]        layer;
    logic [6:0]        bf;
    logic              err_q;
    logic              drained;
    logic [ADDR_W-1:0] gen_a, gen_b, gen_zeta;
    wb_entry_t         wb_line [BT_LAT+1];
`ifdef NTT_CTRL_INTT_EN
    logic              inv_q;
    logic              gen_neg;
`endif

    ntt_addr_gen u_addr_gen (
        .layer    (layer),
`ifdef NTT_CTRL_INTT_EN
        .inv      (inv_q),
        .zeta_neg (gen_neg),
`endif
        .bf       (bf),
        .a        (gen_a),
        .b        (gen_b),
        .zeta_idx (gen_zeta)
    );

    // The tail write completes on the edge that leaves DRAIN, so only the
    // stages ahead of it must be empty before the next layer may read.
    always_comb begin
        drained = 1'b1;
        for (int unsigned i = 0; i < BT_LAT; i++) begin
            if (wb_line[i].valid) drained = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (bf == 7'd127) state_nxt = DRAIN;
            DRAIN:   if (drained) state_nxt = (layer == 3'd7) ? DONE : RUN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        rd_en     = (state == RUN);
        rd_addr_a = rd_en ? gen_a    : '0;
        rd_addr_b = rd_en ? gen_b    : '0;
        zeta_idx  = rd_en ? gen_zeta : '0;
`ifdef NTT_CTRL_INTT_EN
        zeta_neg  = rd_en & gen_neg;
`endif
        bt_en     = wb_line[0].valid;
        wr_en     = wb_line[BT_LAT].valid;
        wr_addr_a = wb_line[BT_LAT].a;
        wr_addr_b = wb_line[BT_LAT].b;
        err       = err_q | (wr_en != bt_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            layer <= '0;
            bf    <= '0;
            err_q <= 1'b0;
`ifdef NTT_CTRL_INTT_EN
            inv_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                layer <= '0;
                bf    <= '0;
                err_q <= 1'b0;
`ifdef NTT_CTRL_INTT_EN
                inv_q <= inv;
`endif
            end else begin
                if (rd_en) bf <= bf + 7'd1;
                if (state == DRAIN && drained) layer <= layer + 3'd1;
                if (wr_en != bt_valid) err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i <= BT_LAT; i++) wb_line[i] <= '0;
        end else begin
            wb_line[0] <= '{valid: rd_en, a: rd_addr_a, b: rd_addr_b};
            for (int unsigned i = 1; i <= BT_LAT; i++) wb_line[i] <= wb_line[i-1];
        end
    end

endmodule
